// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler.
package pulse_sched_pkg;

  localparam int unsigned DEF_N_REQ = 2;
  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  // Zero lengths and counts behave as one so a phase is never skipped.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req searching upward from ptr+1, wrapping.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N     = DEF_N_REQ,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx
);

  logic [N-1:0] rot;
  logic         found;

  always_comb begin
    int unsigned off;
    int unsigned win;
    off   = 0;
    found = 1'b0;
    // Rotate so bit 0 is the requester right after the pointer.
    rot   = N'({req, req} >> (32'(ptr) + 1));
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = j;
      end
    end
    win        = (32'(ptr) + 1 + off) % N;
    win_idx    = IDX_W'(win);
    win_onehot = found ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared pulse-train engine with round-robin arbitration.
// Build option: PULSE_SCHED_ABORT_EN ends a train early when the owner drops req.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] high_len,
  input  logic [N_REQ*LEN_W-1:0] low_len,
  input  logic [N_REQ*CNT_W-1:0] count,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic                   done,
  output logic                   signal
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               signal_q, signal_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   pulses_q, pulses_d;
  logic [LEN_W-1:0]   lat_high_q, lat_high_d;
  logic [LEN_W-1:0]   lat_low_q, lat_low_d;

  logic [N_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [LEN_W-1:0]   high_sel, low_sel;
  logic [CNT_W-1:0]   count_sel;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  assign high_sel  = LEN_W'(high_len >> (win_idx * LEN_W));
  assign low_sel   = LEN_W'(low_len  >> (win_idx * LEN_W));
  assign count_sel = CNT_W'(count    >> (win_idx * CNT_W));

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    signal_d   = signal_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    pulses_d   = pulses_q;
    lat_high_d = lat_high_q;
    lat_low_d  = lat_low_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // Lengths are stored minus one so the phase counter ends at zero.
          lat_high_d = LEN_W'(at_least_one(32'(high_sel)) - 1);
          lat_low_d  = LEN_W'(at_least_one(32'(low_sel)) - 1);
          pulses_d   = CNT_W'(at_least_one(32'(count_sel)));
          phase_d    = LEN_W'(at_least_one(32'(high_sel)) - 1);
          grant_d    = win_onehot;
          ptr_d      = win_idx;
          busy_d     = 1'b1;
          signal_d   = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (phase_q == '0) begin
          state_d  = LOW;
          signal_d = 1'b0;
          phase_d  = lat_low_q;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      LOW: begin
        if (phase_q == '0) begin
          if (pulses_q == CNT_W'(1)) begin
            state_d  = IDLE;
            grant_d  = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pulses_d = '0;
          end else begin
            pulses_d = pulses_q - CNT_W'(1);
            state_d  = HIGH;
            signal_d = 1'b1;
            phase_d  = lat_high_q;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PULSE_SCHED_ABORT_EN
    if ((state_q != IDLE) && ((req & grant_q) == '0)) begin
      state_d  = IDLE;
      grant_d  = '0;
      busy_d   = 1'b0;
      signal_d = 1'b0;
      done_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      signal_q   <= 1'b0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      phase_q    <= '0;
      pulses_q   <= '0;
      lat_high_q <= '0;
      lat_low_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      signal_q   <= signal_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      pulses_q   <= pulses_d;
      lat_high_q <= lat_high_d;
      lat_low_q  <= lat_low_d;
    end
  end

  assign grant  = grant_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign signal = signal_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed self-checking bench for pulse_scheduler (2 requesters, 8-bit lengths, 4-bit counts).
module tb_pulse_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] high_len;
  logic [15:0] low_len;
  logic [7:0]  count;
  logic [1:0]  grant;
  logic        busy;
  logic        done;
  logic        signal;

  int n_checks = 0;
  int n_errors = 0;

  pulse_scheduler #(
    .N_REQ (2),
    .LEN_W (8),
    .CNT_W (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .high_len (high_len),
    .low_len  (low_len),
    .count    (count),
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .signal   (signal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".signal"}, 32'(signal), 0);
    check({tag, ".grant"},  32'(grant),  0);
    check({tag, ".busy"},   32'(busy),   0);
    check({tag, ".done"},   32'(done),   0);
  endtask

  // Steps through one whole train starting at the grant edge, then the done edge.
  // mod_h >= 0 rewrites requester 0's high_len after the first cycle of the train.
  task automatic expect_train(input string tag, input logic [1:0] g,
                              input int h, input int l, input int c, input int mod_h);
    for (int p = 0; p < c; p++) begin
      for (int k = 0; k < h + l; k++) begin
        step();
        check({tag, ".signal"}, 32'(signal), 32'(k < h));
        check({tag, ".grant"},  32'(grant),  32'(g));
        check({tag, ".busy"},   32'(busy),   1);
        check({tag, ".done"},   32'(done),   0);
        if (p == 0 && k == 0 && mod_h >= 0) high_len[7:0] = 8'(mod_h);
      end
    end
    step();
    check({tag, ".end_done"},   32'(done),   1);
    check({tag, ".end_grant"},  32'(grant),  0);
    check({tag, ".end_busy"},   32'(busy),   0);
    check({tag, ".end_signal"}, 32'(signal), 0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = 2'b00;
    high_len = '0;
    low_len  = '0;
    count    = '0;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("idle_no_req");

    // Single 4/4 pulse from requester 0.
    high_len[7:0] = 8'd4; low_len[7:0] = 8'd4; count[3:0] = 4'd1;
    req = 2'b01;
    expect_train("t1", 2'b01, 4, 4, 1, -1);
    req = 2'b00;
    step();
    check_idle("t1_after");

    // Both request after reset: requester 0 first, then requester 1.
    reset = 1'b1; step(); reset = 1'b0;
    high_len = {8'd1, 8'd2}; low_len = {8'd3, 8'd1}; count = {4'd1, 4'd2};
    req = 2'b11;
    expect_train("t2a", 2'b01, 2, 1, 2, -1);
    expect_train("t2b", 2'b10, 1, 3, 1, -1);
    req = 2'b00;
    step();
    check_idle("t2_after");

    // All-zero parameters behave as a single 1/1 pulse.
    high_len = '0; low_len = '0; count = '0;
    req = 2'b01;
    expect_train("t3", 2'b01, 1, 1, 1, -1);
    req = 2'b00;
    step();

    // high_len changes mid-train; only the following grant sees it.
    high_len[7:0] = 8'd4; low_len[7:0] = 8'd2; count[3:0] = 4'd2;
    req = 2'b01;
    expect_train("t4a", 2'b01, 4, 2, 2, 9);
    expect_train("t4b", 2'b01, 9, 2, 2, -1);
    req = 2'b00;
    step();

    // Reset during the third HIGH cycle.
    high_len[7:0] = 8'd5; low_len[7:0] = 8'd2; count[3:0] = 4'd1;
    req = 2'b01;
    step();
    check("t5.h1", 32'(signal), 1);
    step();
    step();
    check("t5.h3", 32'(signal), 1);
    check("t5.h3_busy", 32'(busy), 1);
    reset = 1'b1;
    req   = 2'b11;
    step();
    check_idle("t5.rst");
    reset = 1'b0;
    step();
    check("t5.regrant", 32'(grant), 32'(2'b01));
    check("t5.regrant_sig", 32'(signal), 1);
    reset = 1'b1; req = 2'b00; step(); reset = 1'b0;

    // Owner drops req in its second LOW cycle while requester 1 waits.
    high_len = {8'd1, 8'd2}; low_len = {8'd1, 8'd3}; count = {4'd1, 4'd1};
    req = 2'b11;
    step();
    check("t6.h1", 32'(grant), 32'(2'b01));
    step();
    step();
    check("t6.l1", 32'(signal), 0);
    step();
    check("t6.l2", 32'(signal), 0);
    check("t6.l2_grant", 32'(grant), 32'(2'b01));
    req = 2'b10;
`ifdef PULSE_SCHED_ABORT_EN
    step();
    check_idle("t6.abort");
    step();
    check("t6.next_grant", 32'(grant), 32'(2'b10));
    check("t6.next_sig", 32'(signal), 1);
`else
    step();
    check("t6.l3_sig",   32'(signal), 0);
    check("t6.l3_grant", 32'(grant),  32'(2'b01));
    check("t6.l3_busy",  32'(busy),   1);
    check("t6.l3_done",  32'(done),   0);
    step();
    check("t6.done", 32'(done), 1);
    check("t6.done_grant", 32'(grant), 0);
    step();
    check("t6.next_grant", 32'(grant), 32'(2'b10));
    check("t6.next_sig", 32'(signal), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
